pc_sequencer: RTL

- Owns the program counter for the single-issue MIPS pipeline and drives the IF-stage instruction-memory fetch handshake.
- Resolves control transfers presented by the ID stage and produces the 2-bit next-PC source select used by the next-PC mux, together with the selected next PC.
- Holds a redirect that resolves while the PC cannot advance, so it is not lost during stalls or memory wait states.
- Branch delay slot is architectural; there is no flush.

---
 rtl/pc_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-issue MIPS pipeline.
// Owns the PC, drives the IF fetch handshake, resolves ID-stage control
// transfers into a next-PC source select, and parks a redirect that
// resolves while the PC is held (stall or memory wait) until it can apply.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        imem_ready,
   input  logic        br_valid,
   input  logic [2:0]  br_type,
   input  logic        br_eq,
   input  logic [31:0] id_pc4,
   input  logic [15:0] imm16,
   input  logic [25:0] instr_index,
   input  logic [31:0] rs_val,
   output logic [31:0] pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic        if_valid,
   output logic [1:0]  npcsrc,
   output logic [31:0] npc,
   output logic        addr_err
);

   typedef enum logic [1:0] {BOOT, FETCH, STALL} state_t;

   localparam logic [1:0] SRC_PC4 = 2'b00;
   localparam logic [1:0] SRC_BR  = 2'b01;
   localparam logic [1:0] SRC_J   = 2'b10;
   localparam logic [1:0] SRC_REG = 2'b11;

   state_t      state_q;
   logic [31:0] pc_q;
   logic        pend_valid_q;
   logic [31:0] pend_target_q;
   logic [1:0]  pend_src_q;
   logic        addr_err_q;

   logic        is_beq, is_bne, is_j, is_jr;
   logic        taken;
   logic        advance;
   logic [31:0] br_target, j_target, reg_target;
   logic [1:0]  npcsrc_d;
   logic [31:0] npc_d;

   // Decode the ID-stage transfer and pick the next PC; a parked redirect
   // overrides the live inputs since ID keeps re-presenting the same branch.
   always_comb begin
      is_beq     = (br_type == 3'd1);
      is_bne     = (br_type == 3'd2);
      is_j       = (br_type == 3'd3);
      is_jr      = (br_type == 3'd4);
      taken      = br_valid & ((is_beq & br_eq) | (is_bne & ~br_eq) | is_j | is_jr);
      br_target  = id_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
      j_target   = {id_pc4[31:28], instr_index, 2'b00};
      reg_target = {rs_val[31:2], 2'b00};
      npcsrc_d   = SRC_PC4;
      npc_d      = pc_q + 32'd4;
      if (pend_valid_q) begin
         npcsrc_d = pend_src_q;
         npc_d    = pend_target_q;
      end else if (taken) begin
         if (is_beq || is_bne) begin
            npcsrc_d = SRC_BR;
            npc_d    = br_target;
         end else if (is_j) begin
            npcsrc_d = SRC_J;
            npc_d    = j_target;
         end else begin
            npcsrc_d = SRC_REG;
            npc_d    = reg_target;
         end
      end
   end

   // The PC moves only on an accepted fetch in FETCH with no stall.
   assign advance = (state_q == FETCH) & ~stall & imem_ready;

   // Fetch FSM, PC register, pending redirect and sticky alignment error.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         pend_valid_q  <= 1'b0;
         pend_target_q <= 32'd0;
         pend_src_q    <= SRC_PC4;
         addr_err_q    <= 1'b0;
      end else begin
         case (state_q)
            BOOT:    state_q <= FETCH;
            FETCH:   if (stall) state_q <= STALL;
            STALL:   if (!stall) state_q <= FETCH;
            default: state_q <= BOOT;
         endcase

         if (advance) begin
            // Coinciding redirect loads straight into the PC; nothing parks.
            pc_q         <= npc_d;
            pend_valid_q <= 1'b0;
         end else if (taken && !pend_valid_q) begin
            pend_valid_q  <= 1'b1;
            pend_target_q <= npc_d;
            pend_src_q    <= npcsrc_d;
         end

         if (taken && is_jr && (rs_val[1:0] != 2'b00))
            addr_err_q <= 1'b1;
      end
   end

   assign pc        = pc_q;
   assign imem_addr = pc_q;
   assign imem_req  = (state_q == FETCH);
   assign if_valid  = advance;
   assign npcsrc    = npcsrc_d;
   assign npc       = npc_d;
   assign addr_err  = addr_err_q;

endmodule
